// File: rtl/vx_mask_scanner.sv
// Mask scanner: accepts an N-bit mask and emits the index of each set bit, one per beat,
// in LSB-first (MODE 0) or MSB-first (MODE 1) order. An all-zero mask yields one empty beat.
module vx_mask_scanner #(
    parameter int unsigned N    = 8,
    parameter int unsigned MODE = 0,
    parameter int unsigned LOGN = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_in,
    input  logic [N-1:0]    mask_in,
    output logic            ready_in,
    input  logic            abort,
    output logic            valid_out,
    output logic [LOGN-1:0] index_out,
    output logic            last_out,
    output logic            empty_out,
    input  logic            ready_out
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   pend, pend_nxt;
    logic [LOGN-1:0] idx;
    logic           at_most_one;

    // Index of the next bit to issue: lowest set bit (MODE 0) or highest (MODE 1); 0 when empty.
    function automatic logic [LOGN-1:0] find_index(input logic [N-1:0] m);
        logic [LOGN-1:0] r;
        r = '0;
        if (MODE == 0) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (m[i]) r = LOGN'(i);
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (m[i]) r = LOGN'(i);
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    // Outputs are decoded from the pending register; they cannot move while the beat is stalled.
    always_comb begin
        state_nxt   = state;
        pend_nxt    = pend;
        idx         = find_index(pend);
        at_most_one = ((pend & (pend - N'(1))) == '0);
        valid_out   = (state == S_SCAN);
        index_out   = idx;
        last_out    = valid_out && at_most_one;
        empty_out   = valid_out && (pend == '0);
        ready_in    = (state == S_IDLE) || (valid_out && ready_out && last_out && !abort);

        case (state)
            S_IDLE: begin
                if (valid_in) begin
                    pend_nxt  = mask_in;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (abort) begin
                    pend_nxt  = '0;
                    state_nxt = S_IDLE;
                end else if (ready_out) begin
                    if (last_out) begin
                        // A new mask taken on the final beat keeps the scanner busy without a bubble.
                        if (valid_in) begin
                            pend_nxt = mask_in;
                        end else begin
                            pend_nxt  = '0;
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        pend_nxt = pend & ~(N'(1) << idx);
                    end
                end
            end
            default: begin
                pend_nxt  = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vx_mask_scanner.sv
// Bench for vx_mask_scanner: directed scenarios on LSB-first and MSB-first instances sharing
// stimulus, an N=1 instance, and a randomized run checked against a list-of-indices model.
module tb_vx_mask_scanner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid_in;
    logic [7:0] mask_in;
    logic       abort;
    logic       ready_out;

    logic       ri0, vo0, lo0, eo0;
    logic [2:0] ix0;
    logic       ri1, vo1, lo1, eo1;
    logic [2:0] ix1;

    logic       valid2, mask2, abort2, ready_out2;
    logic       ri2, vo2, lo2, eo2;
    logic [0:0] ix2;

    int passed = 0;
    int total  = 0;

    wire [13:0] obs  = {vo0, ix0, lo0, eo0, ri0, vo1, ix1, lo1, eo1, ri1};
    wire [4:0]  obs2 = {vo2, ix2, lo2, eo2, ri2};

    always #5 clk = ~clk;

    vx_mask_scanner #(.N(8), .MODE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .mask_in(mask_in),
        .ready_in(ri0), .abort(abort), .valid_out(vo0), .index_out(ix0),
        .last_out(lo0), .empty_out(eo0), .ready_out(ready_out)
    );

    vx_mask_scanner #(.N(8), .MODE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .mask_in(mask_in),
        .ready_in(ri1), .abort(abort), .valid_out(vo1), .index_out(ix1),
        .last_out(lo1), .empty_out(eo1), .ready_out(ready_out)
    );

    vx_mask_scanner #(.N(1), .MODE(0)) u2 (
        .clk(clk), .reset_n(reset_n), .valid_in(valid2), .mask_in(mask2),
        .ready_in(ri2), .abort(abort2), .valid_out(vo2), .index_out(ix2),
        .last_out(lo2), .empty_out(eo2), .ready_out(ready_out2)
    );

    // Expected observation for both N=8 instances (a = MODE 0 index, b = MODE 1 index).
    function automatic logic [13:0] beat(input logic v, input logic [2:0] a, input logic [2:0] b,
                                         input logic l, input logic e, input logic r);
        return {v, a, l, e, r, v, b, l, e, r};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] exp;
        #1 reset_n = 1'b0;
        @(negedge clk);
        exp = beat(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        total++;
        if (obs !== exp) $display("FAIL reset_state: got %h want %h", obs, exp);
        else passed++;
        total++;
        if (obs2 !== 5'b00001) $display("FAIL reset_state_n1: got %b want %b", obs2, 5'b00001);
        else passed++;
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_scan_order();
        logic [2:0]  e0 [3];
        logic [2:0]  e1 [3];
        logic [13:0] exp;
        logic        lst;
        e0 = '{3'd2, 3'd5, 3'd7};
        e1 = '{3'd7, 3'd5, 3'd2};
        valid_in = 1'b1; mask_in = 8'hA4; ready_out = 1'b1;
        @(negedge clk);
        total++;
        if ({ri0, ri1} !== 2'b11) $display("FAIL first_accept_ready: got %b want 11", {ri0, ri1});
        else passed++;
        next_cycle();
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lst = (i == 2);
            exp = beat(1'b1, e0[i], e1[i], lst, 1'b0, lst);
            total++;
            if (obs !== exp) $display("FAIL scan_a4_beat%0d: got %h want %h", i, obs, exp);
            else passed++;
            next_cycle();
        end
        valid_in = 1'b1; mask_in = 8'h00;
        next_cycle();
        valid_in = 1'b0;
        @(negedge clk);
        exp = beat(1'b1, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
        total++;
        if (obs !== exp) $display("FAIL zero_mask_beat: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
        @(negedge clk);
        exp = beat(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        total++;
        if (obs !== exp) $display("FAIL zero_mask_done: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp;
        valid_in = 1'b1; mask_in = 8'h01; ready_out = 1'b1;
        next_cycle();
        mask_in = 8'h80;
        @(negedge clk);
        exp = beat(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== exp) $display("FAIL b2b_first: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
        valid_in = 1'b0;
        @(negedge clk);
        exp = beat(1'b1, 3'd7, 3'd7, 1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== exp) $display("FAIL b2b_second: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
        @(negedge clk);
        exp = beat(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        total++;
        if (obs !== exp) $display("FAIL b2b_idle: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [13:0] exp;
        valid_in = 1'b1; mask_in = 8'h0C; ready_out = 1'b0;
        next_cycle();
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = beat(1'b1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
            total++;
            if (obs !== exp) $display("FAIL stall_hold%0d: got %h want %h", i, obs, exp);
            else passed++;
            next_cycle();
        end
        ready_out = 1'b1;
        @(negedge clk);
        exp = beat(1'b1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== exp) $display("FAIL stall_release0: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
        @(negedge clk);
        exp = beat(1'b1, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== exp) $display("FAIL stall_release1: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
    endtask

    task automatic test_abort();
        logic [13:0] exp;
        valid_in = 1'b1; mask_in = 8'hFF; ready_out = 1'b1; abort = 1'b0;
        next_cycle();
        valid_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp = beat(1'b1, 3'(i), 3'(7 - i), 1'b0, 1'b0, 1'b0);
            total++;
            if (obs !== exp) $display("FAIL abort_pre%0d: got %h want %h", i, obs, exp);
            else passed++;
            next_cycle();
        end
        abort = 1'b1;
        @(negedge clk);
        exp = beat(1'b1, 3'd2, 3'd5, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== exp) $display("FAIL abort_cycle: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
        abort = 1'b0; valid_in = 1'b1; mask_in = 8'h10;
        @(negedge clk);
        exp = beat(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        total++;
        if (obs !== exp) $display("FAIL abort_after: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
        valid_in = 1'b0;
        @(negedge clk);
        exp = beat(1'b1, 3'd4, 3'd4, 1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== exp) $display("FAIL abort_next_mask: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
    endtask

    task automatic test_n1();
        valid2 = 1'b1; mask2 = 1'b1;
        @(negedge clk);
        total++;
        if (obs2 !== 5'b00001) $display("FAIL n1_idle: got %b want %b", obs2, 5'b00001);
        else passed++;
        next_cycle();
        mask2 = 1'b0;
        @(negedge clk);
        total++;
        if (obs2 !== 5'b10101) $display("FAIL n1_one: got %b want %b", obs2, 5'b10101);
        else passed++;
        next_cycle();
        valid2 = 1'b0;
        @(negedge clk);
        total++;
        if (obs2 !== 5'b10111) $display("FAIL n1_empty: got %b want %b", obs2, 5'b10111);
        else passed++;
        next_cycle();
        @(negedge clk);
        total++;
        if (obs2 !== 5'b00001) $display("FAIL n1_done: got %b want %b", obs2, 5'b00001);
        else passed++;
        next_cycle();
    endtask

    task automatic test_random();
        int         q0[$];
        int         q1[$];
        logic       ev, el, ee, er;
        logic [2:0] ex0, ex1;
        logic [6:0] exp;
        for (int c = 0; c < 400; c++) begin
            valid_in  = ($urandom_range(0, 1) == 1);
            mask_in   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            ready_out = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            ev  = (q0.size() > 0);
            el  = (q0.size() == 1);
            ee  = ev && (q0[0] < 0);
            er  = !ev || (ready_out && el && !abort);
            ex0 = (ev && q0[0] >= 0) ? 3'(q0[0]) : 3'd0;
            ex1 = (ev && q1[0] >= 0) ? 3'(q1[0]) : 3'd0;
            exp = {ev, ex0, el, ee, er};
            total++;
            if ({vo0, ix0, lo0, eo0, ri0} !== exp)
                $display("FAIL rand_lsb c%0d: got %b want %b", c, {vo0, ix0, lo0, eo0, ri0}, exp);
            else passed++;
            exp = {ev, ex1, el, ee, er};
            total++;
            if ({vo1, ix1, lo1, eo1, ri1} !== exp)
                $display("FAIL rand_msb c%0d: got %b want %b", c, {vo1, ix1, lo1, eo1, ri1}, exp);
            else passed++;
            if (ev && abort) begin
                q0.delete(); q1.delete();
            end else if (ev && ready_out) begin
                void'(q0.pop_front()); void'(q1.pop_front());
            end
            if (valid_in && er) begin
                q0.delete(); q1.delete();
                if (mask_in == 8'h00) begin
                    q0.push_back(-1); q1.push_back(-1);
                end else begin
                    for (int b = 0; b < 8; b++) if (mask_in[b]) q0.push_back(b);
                    for (int b = 7; b >= 0; b--) if (mask_in[b]) q1.push_back(b);
                end
            end
            next_cycle();
        end
        valid_in = 1'b0; abort = 1'b0; ready_out = 1'b1;
        repeat (10) next_cycle();
    endtask

    task automatic test_reset_midscan();
        logic [13:0] exp;
        valid_in = 1'b1; mask_in = 8'hF0; ready_out = 1'b1; abort = 1'b0;
        next_cycle();
        valid_in = 1'b0;
        @(negedge clk);
        exp = beat(1'b1, 3'd4, 3'd7, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== exp) $display("FAIL midscan_beat: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
        #2 reset_n = 1'b0;
        #1;
        exp = beat(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        total++;
        if (obs !== exp) $display("FAIL midscan_async_reset: got %h want %h", obs, exp);
        else passed++;
        next_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs !== exp) $display("FAIL midscan_no_stale%0d: got %h want %h", i, obs, exp);
            else passed++;
            next_cycle();
        end
    endtask

    initial begin
        reset_n = 1'b1; valid_in = 1'b0; mask_in = 8'h00; abort = 1'b0; ready_out = 1'b1;
        valid2 = 1'b0; mask2 = 1'b0; abort2 = 1'b0; ready_out2 = 1'b1;
        test_reset();
        test_scan_order();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_n1();
        test_random();
        test_reset_midscan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
